// File: rtl/signmag_to_twos_pipe_if.sv
// Stream bundle for signmag_to_twos_pipe: sample input with valid/ready, converted output with valid/ready.
// The master drives samples in and accepts results; the slave is the converter.
interface signmag_to_twos_pipe_if #(
  parameter int WIDTH = 34
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sign;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_negated;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_sign, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_negated, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_sign, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_negated, out_zero
  );
endinterface

// File: rtl/signmag_to_twos_pipe.sv
// Two-stage sign/magnitude converter (PASS / ONES / TWOS / ABS) with valid/ready flow control
// and a saturating count of negated samples delivered downstream.
module signmag_to_twos_pipe #(
  parameter int WIDTH = 34,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  signmag_to_twos_pipe_if.slave bus,
  input  logic                 cnt_clear,
  output logic [CNT_W-1:0]     neg_count
);

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_ONES = 2'b01,
    MODE_TWOS = 2'b10,
    MODE_ABS  = 2'b11
  } mode_e;

  localparam logic signed [WIDTH-1:0] ZERO_S = '0;

  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] x, input logic cin);
    return x + {{(WIDTH-1){1'b0}}, cin};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  mode_e                    mode_p0;
  logic signed [WIDTH-1:0]  data_s_p0;
  logic                     neg_p0;
  logic                     cin_p0;
  logic [WIDTH-1:0]         x_p0;

  logic                     vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0]         x_p1_q, x_p1_d;
  logic                     cin_p1_q, cin_p1_d;
  logic                     neg_p1_q, neg_p1_d;
  logic [WIDTH-1:0]         sum_p1;

  logic                     vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0]         data_p2_q, data_p2_d;
  logic                     neg_p2_q, neg_p2_d;
  logic                     zero_p2_q, zero_p2_d;

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     s1_load, s2_load, in_fire, out_fire;

  // Stage 0: decode mode, pick the inversion mask and carry-in
  always_comb begin
    mode_p0   = mode_e'(bus.in_mode);
    data_s_p0 = signed'(bus.in_data);
    neg_p0    = 1'b0;
    case (mode_p0)
      MODE_ONES, MODE_TWOS: neg_p0 = bus.in_sign;
      MODE_ABS:             neg_p0 = data_s_p0 < ZERO_S;
      default:              neg_p0 = 1'b0;
    endcase
    x_p0   = bus.in_data ^ {WIDTH{neg_p0}};
    cin_p0 = neg_p0 && (mode_p0 == MODE_TWOS || mode_p0 == MODE_ABS);
  end

  // A stage may load when its own slot is empty or the slot is emptying this cycle
  assign s2_load  = !vld_p2_q || bus.out_ready;
  assign s1_load  = !vld_p1_q || s2_load;
  assign in_fire  = bus.in_valid && s1_load;
  assign out_fire = vld_p2_q && bus.out_ready;
  assign sum_p1   = wrap_add(x_p1_q, cin_p1_q);

  always_comb begin
    vld_p1_d  = vld_p1_q;
    x_p1_d    = x_p1_q;
    cin_p1_d  = cin_p1_q;
    neg_p1_d  = neg_p1_q;
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    neg_p2_d  = neg_p2_q;
    zero_p2_d = zero_p2_q;
    cnt_d     = cnt_q;

    if (s1_load) vld_p1_d = bus.in_valid;
    if (in_fire) begin
      x_p1_d   = x_p0;
      cin_p1_d = cin_p0;
      neg_p1_d = neg_p0;
    end

    if (s2_load) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        data_p2_d = sum_p1;
        neg_p2_d  = neg_p1_q;
        zero_p2_d = (sum_p1 == '0);
      end
    end

    if (cnt_clear)                 cnt_d = '0;
    else if (out_fire && neg_p2_q) cnt_d = sat_inc(cnt_q);
  end

  // Stage 1 boundary: payload only, qualified by vld_p1_q
  always_ff @(posedge clk) begin
    x_p1_q   <= x_p1_d;
    cin_p1_q <= cin_p1_d;
    neg_p1_q <= neg_p1_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p1_d;
  end

  // Stage 2 boundary: registered outputs and the debug counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      neg_p2_q  <= 1'b0;
      zero_p2_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      neg_p2_q  <= neg_p2_d;
      zero_p2_q <= zero_p2_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready    = s1_load;
  assign bus.out_valid   = vld_p2_q;
  assign bus.out_data    = data_p2_q;
  assign bus.out_negated = neg_p2_q;
  assign bus.out_zero    = zero_p2_q;
  assign neg_count       = cnt_q;

endmodule
